// File: rtl/regex_dfa_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regex_dfa_engine_if                                                  |
// | Stream, table-write and result signals of the DFA regex engine.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface regex_dfa_engine_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int STATE_BITS  = 6,
  parameter int OFFSET_BITS = 16
);
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic [DATA_WIDTH/8-1:0] s_axis_tkeep;
  logic                    s_axis_tvalid;
  logic                    s_axis_tlast;
  logic                    s_axis_tready;
  logic                    tbl_wr_en;
  logic [STATE_BITS+7:0]   tbl_wr_addr;
  logic [STATE_BITS:0]     tbl_wr_data;
  logic                    tbl_wr_err;
  logic                    result_valid;
  logic                    result_hit;
  logic [OFFSET_BITS-1:0]  result_offset;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    input  s_axis_tready, tbl_wr_err, result_valid, result_hit, result_offset
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    output s_axis_tready, tbl_wr_err, result_valid, result_hit, result_offset
  );
endinterface
`default_nettype wire

// File: rtl/regex_dfa_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regex_dfa_engine                                                     |
// | Table-driven DFA scanning one packet byte per cycle, MSB byte first. |
// | Optional macro REGEX_EARLY_EXIT_EN: stop scanning after first accept.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regex_dfa_engine #(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int STATE_BITS          = 6,
  parameter int OFFSET_BITS         = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  regex_dfa_engine_if.slave bus
);
  localparam int c_BYTES = C_S_AXIS_DATA_WIDTH / 8;
  localparam int c_CNT_W = $clog2(c_BYTES) + 1;
  localparam int c_DEPTH = 2 ** (STATE_BITS + 8);
  localparam logic [OFFSET_BITS-1:0] c_IDX_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                         r_state, w_state_nxt;
  logic [C_S_AXIS_DATA_WIDTH-1:0] r_data;
  logic [c_CNT_W-1:0]             r_left;
  logic                           r_last;
  logic [STATE_BITS-1:0]          r_cur_state;
  logic                           r_hit;
  logic [OFFSET_BITS-1:0]         r_offset;
  logic [OFFSET_BITS-1:0]         r_byte_idx;
  logic [OFFSET_BITS-1:0]         r_rd_idx;
  logic                           r_rd_pending;
  logic [STATE_BITS:0]            r_rd_data;
  logic                           r_wr_err;
  logic [STATE_BITS:0]            r_mem [0:c_DEPTH-1];

  logic [c_CNT_W-1:0]             w_n;
  logic                           w_capture;
  logic [STATE_BITS-1:0]          w_state_now;
  logic                           w_accept_now;
  logic                           w_hit;
  logic [OFFSET_BITS-1:0]         w_offset;
  logic                           w_stop;
  logic                           w_issue;
  logic                           w_wr_ok;
  logic                           w_res_hit;
  logic [STATE_BITS+7:0]          w_rd_addr;

  always_comb begin
    w_n = '0;
    for (int i = 0; i < c_BYTES; i++) begin
      w_n = w_n + c_CNT_W'(bus.s_axis_tkeep[i]);
    end
  end

  // Forward the read returning this cycle so the next address uses it.
  assign w_state_now  = r_rd_pending ? r_rd_data[STATE_BITS-1:0] : r_cur_state;
  assign w_accept_now = r_rd_pending && r_rd_data[STATE_BITS];
  assign w_hit        = r_hit || w_accept_now;
  assign w_offset     = (!r_hit && w_accept_now) ? r_rd_idx : r_offset;

`ifdef REGEX_EARLY_EXIT_EN
  assign w_stop = w_hit;
`else
  assign w_stop = 1'b0;
`endif

  assign w_capture = bus.s_axis_tvalid && (r_state == IDLE);
  assign w_issue   = (r_state == SCAN) && !w_stop;
  assign w_wr_ok   = bus.tbl_wr_en && (r_state == IDLE);
  assign w_rd_addr = {w_state_now, r_data[C_S_AXIS_DATA_WIDTH-1 -: 8]};

  // Table storage has no reset so contents survive an engine reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[bus.tbl_wr_addr] <= bus.tbl_wr_data;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_capture) begin
          if (w_n == '0 || w_stop) begin
            w_state_nxt = bus.s_axis_tlast ? DONE : IDLE;
          end else begin
            w_state_nxt = SCAN;
          end
        end
      end
      SCAN: begin
        if (w_stop || r_left == c_CNT_W'(1)) begin
          w_state_nxt = r_last ? DONE : IDLE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_data       <= '0;
      r_left       <= '0;
      r_last       <= 1'b0;
      r_cur_state  <= '0;
      r_hit        <= 1'b0;
      r_offset     <= '0;
      r_byte_idx   <= '0;
      r_rd_idx     <= '0;
      r_rd_pending <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_err     <= bus.tbl_wr_en && (r_state != IDLE);
      r_rd_pending <= w_issue;
      if (w_capture) begin
        r_data <= bus.s_axis_tdata;
        r_left <= w_n;
        r_last <= bus.s_axis_tlast;
      end else if (w_issue) begin
        r_data <= r_data << 8;
        r_left <= r_left - c_CNT_W'(1);
      end
      if (w_issue) begin
        r_rd_idx <= r_byte_idx;
        if (r_byte_idx != c_IDX_MAX) begin
          r_byte_idx <= r_byte_idx + OFFSET_BITS'(1);
        end
      end
      if (r_state == DONE) begin
        r_cur_state <= '0;
        r_hit       <= 1'b0;
        r_offset    <= '0;
        r_byte_idx  <= '0;
      end else begin
        r_cur_state <= w_state_now;
        r_hit       <= w_hit;
        r_offset    <= w_offset;
      end
    end
  end

  assign w_res_hit         = (r_state == DONE) && w_hit;
  assign bus.s_axis_tready = (r_state == IDLE) && !reset;
  assign bus.tbl_wr_err    = r_wr_err;
  assign bus.result_valid  = (r_state == DONE);
  assign bus.result_hit    = w_res_hit;
  assign bus.result_offset = w_res_hit ? w_offset : '0;
endmodule
`default_nettype wire

// File: doc/regex_dfa_engine.md
REGEX_DFA_ENGINE -- requirements
Module: regex_dfa_engine

Interface
REQ-001 Parameter C_S_AXIS_DATA_WIDTH, default 256, SHALL set the stream data width; legal values are multiples of 8 from 64 to 256.
REQ-002 Parameter STATE_BITS, default 6, SHALL set the DFA state width; table depth is 2^(STATE_BITS+8) words.
REQ-003 Parameter OFFSET_BITS, default 16, SHALL set the width of the match-offset output.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  packet bytes; byte 0 = tdata[W-1:W-8], i.e. MSB first.
REQ-007 s_axis_tkeep  in  W/8  byte valid; bit W/8-1 corresponds to byte 0; contiguous from byte 0.
REQ-008 s_axis_tvalid / s_axis_tlast  in  1 each  beat valid / final beat of packet.
REQ-009 s_axis_tready  out  1  beat accepted when tvalid and tready are both high.
REQ-010 tbl_wr_en  in  1; tbl_wr_addr  in  STATE_BITS+8  {state, byte}; tbl_wr_data  in  STATE_BITS+1  {accept, next_state}.
REQ-011 tbl_wr_err  out  1  one-cycle pulse: the write was dropped.
REQ-012 result_valid  out  1  one-cycle pulse per packet; result_hit  out  1; result_offset  out  OFFSET_BITS.

Function
REQ-013 States SHALL be IDLE, SCAN, DONE; reset enters IDLE.
REQ-014 s_axis_tready SHALL be high only in IDLE.
REQ-015 Beat capture in IDLE SHALL latch tdata, the valid-byte count n (number of ones in tkeep) and tlast, then enter SCAN; a beat with n=0 SHALL go straight to DONE if tlast, else stay IDLE.
REQ-016 SCAN SHALL issue one table read per cycle at address {cur_state, byte_k}, k = 0..n-1; read latency is one cycle; cur_state is updated from the read data before the next read is issued, so each valid byte costs one cycle.
REQ-017 With a beat captured at cycle t, its last read SHALL issue at t+n; the engine SHALL return to IDLE at t+n+1 if tlast=0, or enter DONE at t+n+1 if tlast=1.
REQ-018 cur_state SHALL persist across beats of a packet and SHALL return to 0 after DONE.
REQ-019 The first read returning accept=1 SHALL set hit and latch result_offset = packet byte index of that byte; later accepts SHALL not change the offset.
REQ-020 Byte index SHALL count from 0 at the packet's first byte and saturate at 2^OFFSET_BITS-1.
REQ-021 DONE SHALL last one cycle: result_valid=1 with result_hit and result_offset; hit, offset and byte index then clear, and the engine returns to IDLE.
REQ-022 result_hit=0 SHALL drive result_offset=0.
REQ-023 Table writes SHALL be performed only in IDLE; tbl_wr_en in SCAN or DONE SHALL be dropped, and tbl_wr_err SHALL pulse on the next cycle.
REQ-024 A write and a beat capture in the same IDLE cycle SHALL both be taken; the write SHALL be visible to every read issued at t+1 or later.

Reset
REQ-025 Asserting reset SHALL asynchronously force: state=IDLE, cur_state=0, s_axis_tready=0 while reset is high, result_valid=0, result_hit=0, result_offset=0, tbl_wr_err=0.
REQ-026 Reset mid-packet SHALL discard the packet with no result pulse.
REQ-027 Reset SHALL NOT clear table contents.

Configuration
REQ-028 Macro REGEX_EARLY_EXIT_EN: when defined, after the first accept, SCAN SHALL stop issuing reads. Remaining bytes of the current beat are skipped, and the engine leaves SCAN on the next cycle. Each later beat of the packet is accepted and consumed in one cycle, IDLE to IDLE, with no reads.
REQ-029 When REGEX_EARLY_EXIT_EN is undefined, all valid bytes SHALL be scanned regardless of hit; the result values are identical in both builds.

Verification
REQ-030 Table maps state0+'a'->1, state1+'b'->accept|2, all else ->0. Send the 1-beat packet "xxab" with n=4, tlast=1, captured at t -> result_valid at t+5, hit=1, offset=3.
REQ-031 Same table, 2-beat packet: beat0 ends "…a" (32 bytes), beat1 starts "b" -> hit=1, offset=32; confirms cur_state carries across the beat boundary.
REQ-032 Packet containing no "ab" (40 bytes) -> result_valid once, hit=0, offset=0; cur_state is 0 afterwards.
REQ-033 tbl_wr_en pulsed during SCAN -> tbl_wr_err=1 on the next cycle, and a readback scan shows the entry unchanged.
REQ-034 Reset asserted mid-SCAN of a 3-beat packet, then released -> no result_valid, tready=1 in IDLE, and a following "ab" packet gives hit=1, offset=1.
REQ-035 REGEX_EARLY_EXIT_EN build, 3 full beats with "ab" at bytes 0-1 -> beat0 leaves SCAN 3 cycles after capture, and beats 1-2 are accepted on consecutive IDLE cycles.
